// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine inventory controller.
//   SLOT_W / CNT_W / NUM_SLOTS : slot index width, count width, number of slots
//   ST_*                       : transaction FSM encoding
//   req_id_e                   : requester identity (sale or restock)
//   headroom()                 : free capacity left in a slot
package vend_pkg;

  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NUM_SLOTS = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Value doubles as the bit index into the 2-bit req/grant vectors.
  typedef enum logic {
    REQ_SALE = 1'b0,
    REQ_RSTK = 1'b1
  } req_id_e;

  function automatic logic [CNT_W-1:0] headroom(input logic [CNT_W-1:0] cap,
                                                input logic [CNT_W-1:0] cnt);
    return cap - cnt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the sale and restock requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : arbitration cycle (controller idle); rr_last only moves when set
//   i_req      : raw request levels, bit 0 = sale, bit 1 = restock
//   i_armed    : requester eligible (has been seen low since its last ack)
//   o_grant    : one-hot grant, or zero when nobody is eligible
module rr_arb2
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic [1:0] i_armed,
  output logic [1:0] o_grant
);

  req_id_e    r_rr_last;
  logic [1:0] w_elig;

  assign w_elig = i_req & i_armed;

  always_comb begin
    o_grant = 2'b00;
    case (w_elig)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // Tie: whoever did not win the previous tie goes first.
      2'b11:   o_grant = (r_rr_last == REQ_RSTK) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Reset to RSTK so a sale wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= REQ_RSTK;
    end else if (i_en && (w_elig == 2'b11)) begin
      r_rr_last <= o_grant[1] ? REQ_RSTK : REQ_SALE;
    end
  end

endmodule

// File: rtl/slot_txn_ctrl.sv
// Inventory transaction controller: arbitrates sale/restock requests, checks them
// against stock and capacity, commits atomically and publishes per-slot counts.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_admin_mode               : maintenance mode, sales rejected (sampled in CHECK)
//   i_sale_req/slot/qty        : sale request (level, held until o_sale_ack)
//   o_sale_ack, o_sale_ok      : one-cycle completion pulse and its result
//   i_rstk_req/slot/qty        : restock request (level, held until o_rstk_ack)
//   o_rstk_ack, o_rstk_ok      : one-cycle completion pulse and its result
//   o_rest1..4                 : current count of slots 0..3
//   o_max_add1..4              : CAPACITY - count of slots 0..3
//   o_busy                     : transaction in flight
// CAPACITY must be <= 15 and INIT_COUNT <= CAPACITY.
module slot_txn_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CAPACITY   = 15,
  parameter int unsigned INIT_COUNT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_admin_mode,
  input  logic              i_sale_req,
  input  logic [SLOT_W-1:0] i_sale_slot,
  input  logic [CNT_W-1:0]  i_sale_qty,
  output logic              o_sale_ack,
  output logic              o_sale_ok,
  input  logic              i_rstk_req,
  input  logic [SLOT_W-1:0] i_rstk_slot,
  input  logic [CNT_W-1:0]  i_rstk_qty,
  output logic              o_rstk_ack,
  output logic              o_rstk_ok,
  output logic [CNT_W-1:0]  o_rest1,
  output logic [CNT_W-1:0]  o_rest2,
  output logic [CNT_W-1:0]  o_rest3,
  output logic [CNT_W-1:0]  o_rest4,
  output logic [CNT_W-1:0]  o_max_add1,
  output logic [CNT_W-1:0]  o_max_add2,
  output logic [CNT_W-1:0]  o_max_add3,
  output logic [CNT_W-1:0]  o_max_add4,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] CAP_C    = CAPACITY[CNT_W-1:0];
  localparam logic [CNT_W:0]   CAP_SUM  = CAPACITY[CNT_W:0];
  localparam logic [CNT_W-1:0] INIT_C   = INIT_COUNT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MADD_RST = CAP_C - INIT_C;

  logic [1:0]        r_state, w_state_d;
  req_id_e           r_winner, w_winner_d;
  logic [SLOT_W-1:0] r_slot, w_slot_d;
  logic [CNT_W-1:0]  r_qty, w_qty_d;
  logic              r_ok, w_ok_d;
  logic [1:0]        r_armed, w_armed_d;
  logic              r_sale_ack, w_sale_ack_d;
  logic              r_sale_ok, w_sale_ok_d;
  logic              r_rstk_ack, w_rstk_ack_d;
  logic              r_rstk_ok, w_rstk_ok_d;
  logic [CNT_W-1:0]  r_rest    [NUM_SLOTS];
  logic [CNT_W-1:0]  w_rest_d  [NUM_SLOTS];
  logic [CNT_W-1:0]  r_max_add [NUM_SLOTS];
  logic [CNT_W-1:0]  w_max_add_d [NUM_SLOTS];

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic [CNT_W-1:0]  w_cur;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_new;
  logic              w_is_sale;
  logic              w_win_req;
  logic              w_chk_ok;

  assign w_req = {i_rstk_req, i_sale_req};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_state == ST_IDLE),
    .i_req   (w_req),
    .i_armed (r_armed),
    .o_grant (w_grant)
  );

  assign w_is_sale = (r_winner == REQ_SALE);
  assign w_win_req = w_is_sale ? i_sale_req : i_rstk_req;
  assign w_cur     = r_rest[r_slot];
  // One extra bit so an over-capacity restock is caught instead of wrapping.
  assign w_sum     = {1'b0, w_cur} + {1'b0, r_qty};
  assign w_new     = w_is_sale ? (w_cur - r_qty) : w_sum[CNT_W-1:0];

  always_comb begin
    if (w_is_sale) begin
      w_chk_ok = !i_admin_mode && (r_qty != '0) && (r_qty <= w_cur);
    end else begin
      w_chk_ok = (r_qty != '0) && (w_sum <= CAP_SUM);
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_winner_d   = r_winner;
    w_slot_d     = r_slot;
    w_qty_d      = r_qty;
    w_ok_d       = r_ok;
    w_rest_d     = r_rest;
    w_max_add_d  = r_max_add;
    w_sale_ack_d = 1'b0;
    w_sale_ok_d  = 1'b0;
    w_rstk_ack_d = 1'b0;
    w_rstk_ok_d  = 1'b0;

    // A low request re-arms its requester; the ack below disarms it, so a req
    // held past its ack cannot be granted a second time.
    w_armed_d = r_armed | ~w_req;

    case (r_state)
      ST_IDLE: begin
        if (w_grant != 2'b00) begin
          w_winner_d = w_grant[1] ? REQ_RSTK : REQ_SALE;
          w_slot_d   = w_grant[1] ? i_rstk_slot : i_sale_slot;
          w_qty_d    = w_grant[1] ? i_rstk_qty : i_sale_qty;
          w_state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Requester withdrew: drop the transaction silently.
        if (!w_win_req) begin
          w_state_d = ST_IDLE;
        end else begin
          w_ok_d    = w_chk_ok;
          w_state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (r_ok) begin
          w_rest_d[r_slot]    = w_new;
          w_max_add_d[r_slot] = headroom(CAP_C, w_new);
        end
        if (w_is_sale) begin
          w_sale_ack_d = 1'b1;
          w_sale_ok_d  = r_ok;
          w_armed_d[0] = 1'b0;
        end else begin
          w_rstk_ack_d = 1'b1;
          w_rstk_ok_d  = r_ok;
          w_armed_d[1] = 1'b0;
        end
        w_state_d = ST_RESP;
      end
      ST_RESP: begin
        w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_winner   <= REQ_SALE;
      r_slot     <= '0;
      r_qty      <= '0;
      r_ok       <= 1'b0;
      r_armed    <= 2'b11;
      r_sale_ack <= 1'b0;
      r_sale_ok  <= 1'b0;
      r_rstk_ack <= 1'b0;
      r_rstk_ok  <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        r_rest[i]    <= INIT_C;
        r_max_add[i] <= MADD_RST;
      end
    end else begin
      r_state    <= w_state_d;
      r_winner   <= w_winner_d;
      r_slot     <= w_slot_d;
      r_qty      <= w_qty_d;
      r_ok       <= w_ok_d;
      r_armed    <= w_armed_d;
      r_sale_ack <= w_sale_ack_d;
      r_sale_ok  <= w_sale_ok_d;
      r_rstk_ack <= w_rstk_ack_d;
      r_rstk_ok  <= w_rstk_ok_d;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        r_rest[i]    <= w_rest_d[i];
        r_max_add[i] <= w_max_add_d[i];
      end
    end
  end

  assign o_sale_ack = r_sale_ack;
  assign o_sale_ok  = r_sale_ok;
  assign o_rstk_ack = r_rstk_ack;
  assign o_rstk_ok  = r_rstk_ok;
  assign o_busy     = (r_state != ST_IDLE);

  assign o_rest1    = r_rest[0];
  assign o_rest2    = r_rest[1];
  assign o_rest3    = r_rest[2];
  assign o_rest4    = r_rest[3];
  assign o_max_add1 = r_max_add[0];
  assign o_max_add2 = r_max_add[1];
  assign o_max_add3 = r_max_add[2];
  assign o_max_add4 = r_max_add[3];

endmodule

// File: tb/tb_slot_txn_ctrl.sv
// Scoreboard bench for slot_txn_ctrl (CAPACITY=15, INIT_COUNT=0).
// The driver pushes the expected outcome of each request into a queue; a monitor
// pops and compares whenever an ack appears.
module tb_slot_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       admin_mode;
  logic       sale_req, rstk_req;
  logic [1:0] sale_slot, rstk_slot;
  logic [3:0] sale_qty, rstk_qty;
  logic       sale_ack, sale_ok, rstk_ack, rstk_ok, busy;
  logic [3:0] rest1, rest2, rest3, rest4;
  logic [3:0] madd1, madd2, madd3, madd4;

  always #5 clk = ~clk;

  slot_txn_ctrl #(
    .CAPACITY   (15),
    .INIT_COUNT (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_admin_mode (admin_mode),
    .i_sale_req   (sale_req),
    .i_sale_slot  (sale_slot),
    .i_sale_qty   (sale_qty),
    .o_sale_ack   (sale_ack),
    .o_sale_ok    (sale_ok),
    .i_rstk_req   (rstk_req),
    .i_rstk_slot  (rstk_slot),
    .i_rstk_qty   (rstk_qty),
    .o_rstk_ack   (rstk_ack),
    .o_rstk_ok    (rstk_ok),
    .o_rest1      (rest1),
    .o_rest2      (rest2),
    .o_rest3      (rest3),
    .o_rest4      (rest4),
    .o_max_add1   (madd1),
    .o_max_add2   (madd2),
    .o_max_add3   (madd3),
    .o_max_add4   (madd4),
    .o_busy       (busy)
  );

  typedef struct {
    bit          id;   // 0 = sale, 1 = restock
    bit          ok;
    logic [15:0] rest;
    logic [15:0] madd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cnt[4];
  int   t_sale, t_rstk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack_rest();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(cnt[i]);
    return r;
  endfunction

  function automatic logic [15:0] pack_madd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(15 - cnt[i]);
    return r;
  endfunction

  // Reference model: stock rules with plain integer arithmetic.
  task automatic model_push(input bit is_rstk, input int slot, input int qty, input bit admin);
    exp_t e;
    bit   ok;
    if (is_rstk) ok = (qty != 0) && (cnt[slot] + qty <= 15);
    else         ok = !admin && (qty != 0) && (qty <= cnt[slot]);
    if (ok) cnt[slot] = is_rstk ? cnt[slot] + qty : cnt[slot] - qty;
    e.id   = is_rstk;
    e.ok   = ok;
    e.rest = pack_rest();
    e.madd = pack_madd();
    q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (sale_ack || rstk_ack)) begin
      chk("ack_both_high", 32'(sale_ack & rstk_ack), 32'd0);
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: sale_ack=%0d rstk_ack=%0d, expected no ack (t=%0t)",
                 sale_ack, rstk_ack, $time);
      end else begin
        mon_e = q.pop_front();
        chk("ack_id", 32'(rstk_ack), 32'(mon_e.id));
        chk("ack_ok", 32'(rstk_ack ? rstk_ok : sale_ok), 32'(mon_e.ok));
        chk("rest", 32'({rest4, rest3, rest2, rest1}), 32'(mon_e.rest));
        chk("max_add", 32'({madd4, madd3, madd2, madd1}), 32'(mon_e.madd));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rest"}, 32'({rest4, rest3, rest2, rest1}), 32'h0000);
    chk({tag, "_max_add"}, 32'({madd4, madd3, madd2, madd1}), 32'hFFFF);
    chk({tag, "_acks"}, 32'({sale_ack, sale_ok, rstk_ack, rstk_ok}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Single request from an idle DUT; slot/qty are scrambled after the grant.
  task automatic do_op(input bit is_rstk, input int slot, input int qty);
    int k;
    bit got;
    @(posedge clk);
    #1;
    model_push(is_rstk, slot, qty, admin_mode);
    if (is_rstk) begin
      rstk_slot = 2'(slot); rstk_qty = 4'(qty); rstk_req = 1'b1;
    end else begin
      sale_slot = 2'(slot); sale_qty = 4'(qty); sale_req = 1'b1;
    end
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        if (is_rstk) begin rstk_slot = 2'($urandom); rstk_qty = 4'($urandom); end
        else         begin sale_slot = 2'($urandom); sale_qty = 4'($urandom); end
      end
      got = is_rstk ? rstk_ack : sale_ack;
    end
    chk("ack_latency", 32'(k), 32'd4);
    @(posedge clk);
    #1;
    if (is_rstk) rstk_req = 1'b0;
    else         sale_req = 1'b0;
  endtask

  // Hold a request, acknowledge three grants, dropping req for one cycle after each.
  task automatic hold_loop(input bit is_rstk, output int first_cyc);
    int k;
    bit got;
    first_cyc = -1;
    for (int n = 0; n < 3; n++) begin
      k   = 0;
      got = 1'b0;
      while (!got && k < 40) begin
        @(negedge clk);
        k++;
        got = is_rstk ? rstk_ack : sale_ack;
      end
      chk(is_rstk ? "tie_rstk_ack_seen" : "tie_sale_ack_seen", 32'(got), 32'd1);
      if (n == 0) first_cyc = cyc;
      @(posedge clk);
      #1;
      if (is_rstk) rstk_req = 1'b0; else sale_req = 1'b0;
      @(posedge clk);
      #1;
      if (is_rstk) rstk_req = (n < 2); else sale_req = (n < 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    admin_mode = 1'b0;
    sale_req   = 1'b0; sale_slot = '0; sale_qty = '0;
    rstk_req   = 1'b0; rstk_slot = '0; rstk_qty = '0;
    model_reset();
    #22;
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic restock/sale, capacity boundary, admin mode, zero quantity.
    do_op(1'b1, 2, 7);
    do_op(1'b0, 2, 8);
    do_op(1'b0, 2, 7);
    do_op(1'b1, 0, 10);
    do_op(1'b1, 0, 6);
    do_op(1'b1, 0, 5);
    do_op(1'b1, 1, 3);
    admin_mode = 1'b1;
    do_op(1'b0, 1, 1);
    do_op(1'b1, 1, 1);
    admin_mode = 1'b0;
    do_op(1'b0, 1, 2);
    do_op(1'b0, 0, 0);
    do_op(1'b1, 3, 0);

    // Winner withdraws during CHECK: no ack, no change.
    @(posedge clk);
    #1 sale_slot = 2'd0; sale_qty = 4'd1; sale_req = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy_in_check", 32'(busy), 32'd1);
    sale_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_rest", 32'({rest4, rest3, rest2, rest1}), 32'(pack_rest()));
    chk("abort_max_add", 32'({madd4, madd3, madd2, madd1}), 32'(pack_madd()));

    // Reset asserted while the restock is in COMMIT.
    @(posedge clk);
    #1 rstk_slot = 2'd3; rstk_qty = 4'd4; rstk_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("commit_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    rstk_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("post_reset");

    // Simultaneous requests after reset: sale first, then strict alternation.
    for (int j = 0; j < 3; j++) begin
      model_push(1'b0, 0, 1, 1'b0);
      model_push(1'b1, 0, 2, 1'b0);
    end
    @(posedge clk);
    #1;
    sale_slot = 2'd0; sale_qty = 4'd1;
    rstk_slot = 2'd0; rstk_qty = 4'd2;
    sale_req  = 1'b1; rstk_req = 1'b1;
    fork
      hold_loop(1'b0, t_sale);
      hold_loop(1'b1, t_rstk);
    join
    chk("tie_ack_gap", 32'(t_rstk - t_sale), 32'd4);

    // Randomised single transactions.
    repeat (80) begin
      admin_mode = ($urandom_range(0, 4) == 0);
      do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
    end
    admin_mode = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
